// File: rtl/codificador_corriente_pkg.sv
// Current-table constants and FSM state encoding, shared by the forward lookup
// memory and by the current-to-index encoder so both use identical values.
package pkg_corrientes;

    localparam int unsigned ANCHO_I    = 10;
    localparam int unsigned ANCHO_IDX  = 4;
    localparam int unsigned N_ENTRADAS = 16;
    localparam int unsigned PASO_TABLA = 64;

    typedef logic [1:0] estado_t;
    localparam estado_t REPOSO = 2'd0;
    localparam estado_t BUSCA  = 2'd1;
    localparam estado_t LISTO  = 2'd2;

    // T(k) = 64*k, k = 0..15
    function automatic int unsigned valor_tabla(input int unsigned k);
        return k * PASO_TABLA;
    endfunction

endpackage

// File: rtl/codificador_corriente_tabla.sv
// Combinational read of the current table T(k) from the shared package values.
module tabla_corrientes_rom #(
    parameter int unsigned ANCHO_I   = pkg_corrientes::ANCHO_I,
    parameter int unsigned ANCHO_IDX = pkg_corrientes::ANCHO_IDX
) (
    input  logic [ANCHO_IDX-1:0] dir,
    output logic [ANCHO_I-1:0]   dato
);
    import pkg_corrientes::*;

    always_comb begin
        dato = ANCHO_I'(valor_tabla(32'(dir)));
    end

endmodule

// File: rtl/codificador_corriente.sv
// Sequential current-to-index encoder: scans the table one entry per clock.
// Optional round-to-nearest result selected by defining CORR_REDONDEO_EN.
module codificador_corriente #(
    parameter int unsigned N_ENTRADAS = pkg_corrientes::N_ENTRADAS,
    parameter int unsigned ANCHO_I    = pkg_corrientes::ANCHO_I,
    parameter int unsigned ANCHO_IDX  = pkg_corrientes::ANCHO_IDX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inicio,
    input  logic [ANCHO_I-1:0]   I_obj,
    output logic                 ocupado,
    output logic                 valido,
    output logic [ANCHO_IDX-1:0] corriente,
    output logic                 saturado
);
    import pkg_corrientes::*;

    localparam logic [ANCHO_IDX-1:0] K_ULTIMO = ANCHO_IDX'(N_ENTRADAS - 1);
    localparam logic [ANCHO_I-1:0]   T_ULTIMO = ANCHO_I'(valor_tabla(N_ENTRADAS - 1));

    estado_t              estado;
    logic [ANCHO_IDX-1:0] k;
    logic [ANCHO_IDX-1:0] k_sig;
    logic [ANCHO_IDX-1:0] resultado;
    logic [ANCHO_I-1:0]   objetivo;
    logic [ANCHO_I-1:0]   t_sig;
    logic                 es_ultimo;
    logic                 parar;
    logic                 sat_pend;

    // k_sig wraps at the last entry, but t_sig is never used there
    assign k_sig     = k + ANCHO_IDX'(1);
    assign es_ultimo = (k == K_ULTIMO);
    assign parar     = es_ultimo || (t_sig > objetivo);

    tabla_corrientes_rom #(
        .ANCHO_I   (ANCHO_I),
        .ANCHO_IDX (ANCHO_IDX)
    ) u_rom_sig (
        .dir  (k_sig),
        .dato (t_sig)
    );

`ifdef CORR_REDONDEO_EN
    logic [ANCHO_I-1:0] t_act;

    tabla_corrientes_rom #(
        .ANCHO_I   (ANCHO_I),
        .ANCHO_IDX (ANCHO_IDX)
    ) u_rom_act (
        .dir  (k),
        .dato (t_act)
    );

    // target >= T(k) holds here, so both differences are non-negative; ties stay low
    always_comb begin
        resultado = k;
        if (!es_ultimo && ((t_sig - objetivo) < (objetivo - t_act))) begin
            resultado = k_sig;
        end
    end
`else
    always_comb begin
        resultado = k;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado    <= REPOSO;
            k         <= '0;
            objetivo  <= '0;
            sat_pend  <= 1'b0;
            ocupado   <= 1'b0;
            valido    <= 1'b0;
            corriente <= '0;
            saturado  <= 1'b0;
        end else begin
            valido <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (inicio) begin
                        objetivo <= I_obj;
                        k        <= '0;
                        ocupado  <= 1'b1;
                        estado   <= BUSCA;
                    end
                end
                BUSCA: begin
                    if (parar) begin
                        k        <= resultado;
                        sat_pend <= es_ultimo && (objetivo > T_ULTIMO);
                        estado   <= LISTO;
                    end else begin
                        k <= k_sig;
                    end
                end
                LISTO: begin
                    corriente <= k;
                    saturado  <= sat_pend;
                    valido    <= 1'b1;
                    ocupado   <= 1'b0;
                    estado    <= REPOSO;
                end
                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

endmodule
